// File: rtl/bmp_stream_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bmp_stream_writer_if
//  Purpose  : Bundles the BMP framer's control, pixel-FIFO read side and
//             byte-FIFO write side into one port.
//  Signals  : start     - one-cycle frame request
//             in_dout   - pixel at head of input FIFO (FWFT)
//             in_empty  - input FIFO empty
//             in_rd_en  - input FIFO pop
//             out_din   - byte to output FIFO
//             out_wr_en - output FIFO write strobe
//             out_full  - output FIFO full
//             busy      - frame in progress
//             done      - end-of-frame pulse
//  Modports : master - the framer; slave - its environment
//  Revision : 1.0 - initial release
// ============================================================================
interface bmp_stream_writer_if;
    logic        start;
    logic [23:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [7:0]  out_din;
    logic        out_wr_en;
    logic        out_full;
    logic        busy;
    logic        done;

    modport master (
        input  start, in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_wr_en, busy, done
    );

    modport slave (
        output start, in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_wr_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bmp_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : bmp_stream_writer
//  Purpose  : BMP framer. Emits a 54-byte BMP header built from parameters,
//             then pops 24-bit pixels from an FWFT FIFO and serializes them
//             LSB byte first into a byte FIFO, zero-padding every row to a
//             4-byte stride.
//  Ports    : clock - rising-edge clock
//             reset - synchronous, active-low reset
//             bus   - bmp_stream_writer_if.master (start, pixel FIFO read
//                     side, byte FIFO write side, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
module bmp_stream_writer #(
    parameter int unsigned BMP_WIDTH  = 720,
    parameter int unsigned BMP_HEIGHT = 540,
    parameter int unsigned DWIDTH     = 24,
    parameter int unsigned PPM        = 2835
) (
    input  wire logic           clock,
    input  wire logic           reset,
    bmp_stream_writer_if.master bus
);

    // ------------------------------------------------------------------
    // Frame geometry
    // ------------------------------------------------------------------
    localparam logic [31:0] c_ROW_BYTES = 32'(3 * BMP_WIDTH);
    localparam logic [31:0] c_STRIDE    = (c_ROW_BYTES + 32'd3) & ~32'd3;
    localparam logic [31:0] c_PAD       = c_STRIDE - c_ROW_BYTES;
    localparam logic [31:0] c_IMG_SIZE  = c_STRIDE * 32'(BMP_HEIGHT);
    localparam logic [31:0] c_FILE_SIZE = 32'd54 + c_IMG_SIZE;

    localparam logic [5:0]  c_HDR_LAST  = 6'd53;
    localparam logic [5:0]  c_PAD_LAST  = (c_PAD == 32'd0) ? 6'd0 : 6'(c_PAD - 32'd1);
    localparam logic [11:0] c_COL_LAST  = 12'(BMP_WIDTH - 1);
    localparam logic [11:0] c_ROWS      = 12'(BMP_HEIGHT);

    // Header image: byte i lives at bits [8*i +: 8], so every 32/16-bit
    // field placed here lands little-endian in the byte stream.
    localparam logic [431:0] c_HEADER = {
        32'd0,              // 50..53 important colours
        32'd0,              // 46..49 palette colours
        32'(PPM),           // 42..45 vertical resolution
        32'(PPM),           // 38..41 horizontal resolution
        c_IMG_SIZE,         // 34..37 image size
        32'd0,              // 30..33 compression
        16'd24,             // 28..29 bits per pixel
        16'd1,              // 26..27 planes
        32'(BMP_HEIGHT),    // 22..25 height (positive: bottom-up)
        32'(BMP_WIDTH),     // 18..21 width
        32'd40,             // 14..17 info header size
        32'd54,             // 10..13 pixel data offset
        32'd0,              //  6..9  reserved
        c_FILE_SIZE,        //  2..5  file size
        8'h4D, 8'h42        //  0..1  "BM"
    };

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HEADER = 3'd1;
    localparam logic [2:0] c_ST_LOAD   = 3'd2;
    localparam logic [2:0] c_ST_EMIT   = 3'd3;
    localparam logic [2:0] c_ST_PAD    = 3'd4;
    localparam logic [2:0] c_ST_FINISH = 3'd5;

    logic [2:0]        r_state, w_state_nxt;
    logic [5:0]        r_idx,   w_idx_nxt;   // header byte / pixel byte / pad byte
    logic [11:0]       r_col,   w_col_nxt;
    logic [11:0]       r_row,   w_row_nxt;
    logic [DWIDTH-1:0] r_pix,   w_pix_nxt;

    logic       w_wr_en;
    logic       w_rd_en;
    logic [7:0] w_din;
    logic       w_busy;
    logic       w_done;
    logic       w_row_end;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_pix_nxt   = r_pix;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_din       = 8'h00;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_row_end   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_HEADER;
                    w_idx_nxt   = 6'd0;
                    w_col_nxt   = 12'd0;
                    w_row_nxt   = 12'd0;
                end
            end

            c_ST_HEADER: begin
                w_busy  = 1'b1;
                w_din   = c_HEADER[{r_idx, 3'b000} +: 8];
                w_wr_en = ~bus.out_full;
                if (w_wr_en) begin
                    if (r_idx == c_HDR_LAST) begin
                        w_idx_nxt   = 6'd0;
                        w_state_nxt = c_ST_LOAD;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end
            end

            // No output write here, so a pop goes ahead even when the
            // output FIFO is full.
            c_ST_LOAD: begin
                w_busy  = 1'b1;
                w_rd_en = ~bus.in_empty;
                if (w_rd_en) begin
                    w_pix_nxt   = bus.in_dout;
                    w_idx_nxt   = 6'd0;
                    w_state_nxt = c_ST_EMIT;
                end
            end

            c_ST_EMIT: begin
                w_busy = 1'b1;
                case (r_idx[1:0])
                    2'd0:    w_din = r_pix[7:0];
                    2'd1:    w_din = r_pix[15:8];
                    default: w_din = r_pix[23:16];
                endcase
                w_wr_en = ~bus.out_full;
                if (w_wr_en) begin
                    if (r_idx == 6'd2) begin
                        w_idx_nxt = 6'd0;
                        if (r_col == c_COL_LAST) begin
                            w_col_nxt = 12'd0;
                            if (c_PAD != 32'd0) begin
                                w_state_nxt = c_ST_PAD;
                            end else begin
                                w_row_end = 1'b1;
                            end
                        end else begin
                            w_col_nxt   = r_col + 12'd1;
                            w_state_nxt = c_ST_LOAD;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end
            end

            c_ST_PAD: begin
                w_busy  = 1'b1;
                w_wr_en = ~bus.out_full;
                if (w_wr_en) begin
                    if (r_idx == c_PAD_LAST) begin
                        w_idx_nxt = 6'd0;
                        w_row_end = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end
            end

            c_ST_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Shared end-of-row step, reached from EMIT (no padding) or PAD.
        if (w_row_end) begin
            w_row_nxt   = r_row + 12'd1;
            w_state_nxt = ((r_row + 12'd1) == c_ROWS) ? c_ST_FINISH : c_ST_LOAD;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 6'd0;
            r_col   <= 12'd0;
            r_row   <= 12'd0;
            r_pix   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_pix   <= w_pix_nxt;
        end
    end

    assign bus.out_wr_en = w_wr_en;
    assign bus.out_din   = w_din;
    assign bus.in_rd_en  = w_rd_en;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
`default_nettype wire
